// File: rtl/pattern_sequencer_if.sv
// Configuration handshake bundle between the register logic (master) and
// the pattern sequencer (slave).
interface pattern_sequencer_if #(
  parameter int PW = 3
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_pattern;
  logic [7:0]    cfg_hold;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_pattern,
    output cfg_hold,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_pattern,
    input  cfg_hold,
    output cfg_ready
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test pattern controller: configuration writes are held
// pending and committed only at the leading edge of vsync; optional auto-cycling.
module pattern_sequencer #(
  parameter int NUM_PATTERNS    = 8,
  parameter int DEFAULT_PATTERN = 0,
  parameter bit video_vsync_pol = 1'b0,
  localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  input  logic                 video_vsync,
  pattern_sequencer_if.slave   cfg,
  output logic [PW-1:0]        pattern_select,
  output logic                 pattern_blank,
  output logic                 frame_start,
  output logic                 cfg_applied,
  output logic [15:0]          frame_count
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_BLANK  = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  state_t        state_r, state_nxt_s;
  logic          vs_q_r;
  logic          vs_act_s, frame_edge_s, xfer_s;
  logic [1:0]    pend_mode_r;
  logic [PW-1:0] pend_pattern_r;
  logic [7:0]    pend_hold_r;
  logic [1:0]    mode_r, mode_nxt_s;
  logic [7:0]    hold_r, hold_nxt_s;
  logic [7:0]    hold_cnt_r, hold_cnt_nxt_s;
  logic [7:0]    hold_max_s;
  logic [PW-1:0] pattern_r, pattern_nxt_s, pattern_inc_s;
  logic          blank_r, blank_nxt_s;
  logic          applied_r, applied_nxt_s;
  logic          frame_start_r;
  logic [15:0]   frame_count_r;

  assign vs_act_s      = (video_vsync == video_vsync_pol);
  assign frame_edge_s  = vs_act_s & ~vs_q_r;
  assign xfer_s        = cfg.cfg_valid & (state_r == ST_IDLE);
  assign hold_max_s    = (hold_r == 8'd0) ? 8'd1 : hold_r;
  assign pattern_inc_s = (pattern_r == PW'(NUM_PATTERNS - 1)) ? {PW{1'b0}} : pattern_r + PW'(1);

  assign cfg.cfg_ready    = (state_r == ST_IDLE);
  assign pattern_select   = pattern_r;
  assign pattern_blank    = blank_r;
  assign frame_start      = frame_start_r;
  assign cfg_applied      = applied_r;
  assign frame_count      = frame_count_r;

  // Handshake FSM state register
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a transfer coinciding with a frame edge still waits for the next edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          state_nxt_s = ST_PENDING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frame_edge_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-frame update of active configuration; a commit overrides any auto-advance
  always_comb begin
    mode_nxt_s     = mode_r;
    hold_nxt_s     = hold_r;
    hold_cnt_nxt_s = hold_cnt_r;
    pattern_nxt_s  = pattern_r;
    blank_nxt_s    = blank_r;
    applied_nxt_s  = 1'b0;
    if (frame_edge_s && (state_r == ST_PENDING)) begin
      mode_nxt_s     = pend_mode_r;
      hold_nxt_s     = pend_hold_r;
      hold_cnt_nxt_s = 8'd0;
      pattern_nxt_s  = pend_pattern_r;
      blank_nxt_s    = (pend_mode_r == MODE_BLANK);
      applied_nxt_s  = 1'b1;
    end else if (frame_edge_s) begin
      case (mode_r)
        MODE_AUTO: begin
          if (hold_cnt_r == (hold_max_s - 8'd1)) begin
            hold_cnt_nxt_s = 8'd0;
            pattern_nxt_s  = pattern_inc_s;
          end else begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
          end
        end
        MODE_STATIC: pattern_nxt_s = pattern_r;
        MODE_BLANK:  blank_nxt_s   = 1'b1;
        MODE_FREEZE: hold_cnt_nxt_s = hold_cnt_r;
        default:     pattern_nxt_s = pattern_r;
      endcase
    end else begin
      applied_nxt_s = 1'b0;
    end
  end

  // Datapath registers; vs_q resets active so a held vsync at release is not an edge
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      vs_q_r         <= 1'b1;
      pend_mode_r    <= MODE_STATIC;
      pend_pattern_r <= {PW{1'b0}};
      pend_hold_r    <= 8'd0;
      mode_r         <= MODE_STATIC;
      hold_r         <= 8'd0;
      hold_cnt_r     <= 8'd0;
      pattern_r      <= PW'(DEFAULT_PATTERN);
      blank_r        <= 1'b0;
      applied_r      <= 1'b0;
      frame_start_r  <= 1'b0;
      frame_count_r  <= 16'd0;
    end else begin
      vs_q_r <= vs_act_s;
      if (xfer_s) begin
        pend_mode_r    <= cfg.cfg_mode;
        pend_pattern_r <= cfg.cfg_pattern;
        pend_hold_r    <= cfg.cfg_hold;
      end
      mode_r        <= mode_nxt_s;
      hold_r        <= hold_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      pattern_r     <= pattern_nxt_s;
      blank_r       <= blank_nxt_s;
      applied_r     <= applied_nxt_s;
      frame_start_r <= frame_edge_s;
      if (frame_edge_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

endmodule
